// File: rtl/dualportram_param.sv
// Parametrised true dual-port synchronous RAM with byte enables, selectable
// read-during-write, optional output register and a post-reset zero sweep.
module dualportram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   dout_a,
  output logic [DATA_W-1:0]   dout_b,
  output logic                valid_a,
  output logic                valid_b,
  output logic                init_busy,
  output logic                collision
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  // state | meaning
  // CLEAR | zero sweep in progress, one word per cycle, ports ignored
  // READY | normal dual-port operation
  typedef enum logic {CLEAR, READY} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  clr_ptr, clr_ptr_nx;
  logic               clr_we, ready;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               acc_a, acc_b, wr_a, wr_b;
  logic [DATA_W-1:0]  rd_word_a, rd_word_b;
  logic [DATA_W-1:0]  rd_q_a, rd_q_b;
  logic               rd_v_a, rd_v_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nx = clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nx = READY;
      end
      default: state_nx = READY;
    endcase
  end

  always_comb begin
    clr_we    = (state == CLEAR);
    ready     = (state == READY) && !rst;
    init_busy = rst || (state != READY);
  end

  assign acc_a = en_a & ready;
  assign acc_b = en_b & ready;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;

  // Port B lanes are written first so port A wins overlapping lanes on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
        if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      end
    end
  end

  // Write-first merges only the reading port's own lanes; the other port's write is never forwarded.
  always_comb begin
    rd_word_a = mem[addr_a];
    rd_word_b = mem[addr_b];
    if (RDW_MODE == 1) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_a && be_a[i]) rd_word_a[8*i +: 8] = din_a[8*i +: 8];
        if (wr_b && be_b[i]) rd_word_b[8*i +: 8] = din_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q_a    <= '0;
      rd_q_b    <= '0;
      rd_v_a    <= 1'b0;
      rd_v_b    <= 1'b0;
      collision <= 1'b0;
    end else begin
      rd_v_a    <= acc_a;
      rd_v_b    <= acc_b;
      collision <= wr_a && wr_b && (addr_a == addr_b) && ((be_a & be_b) != '0);
      if (acc_a) rd_q_a <= rd_word_a;
      if (acc_b) rd_q_b <= rd_word_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_a  <= '0;
          dout_b  <= '0;
          valid_a <= 1'b0;
          valid_b <= 1'b0;
        end else begin
          valid_a <= rd_v_a;
          valid_b <= rd_v_b;
          if (rd_v_a) dout_a <= rd_q_a;
          if (rd_v_b) dout_b <= rd_q_b;
        end
      end
    end else begin : g_direct
      assign dout_a  = rd_q_a;
      assign dout_b  = rd_q_b;
      assign valid_a = rd_v_a;
      assign valid_b = rd_v_b;
    end
  endgenerate
endmodule

// File: tb/tb_dualportram_param.sv
// Scoreboard bench: two DUT copies (read-first/latency 1 and write-first/latency 2)
// share one stimulus stream checked against an array model of the memory.
module tb_dualportram_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        valid_a0, valid_b0, valid_a1, valid_b1;
  logic        busy0, busy1, col0, col1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[4][$];
  int          qc[2][$];
  logic [15:0] mem_m [16];
  logic [15:0] dv [4];
  logic        vv [4];
  logic        cv [2];
  logic [15:0] last [4];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dualportram_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a0), .dout_b(dout_b0), .valid_a(valid_a0), .valid_b(valid_b0),
    .init_busy(busy0), .collision(col0)
  );

  dualportram_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a1), .dout_b(dout_b1), .valid_a(valid_a1), .valid_b(valid_b1),
    .init_busy(busy1), .collision(col1)
  );

  assign dv[0] = dout_a0;  assign vv[0] = valid_a0;
  assign dv[1] = dout_b0;  assign vv[1] = valid_b0;
  assign dv[2] = dout_a1;  assign vv[2] = valid_a1;
  assign dv[3] = dout_b1;  assign vv[3] = valid_b1;
  assign cv[0] = col0;     assign cv[1] = col1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = din[7:0];
    if (be[1]) r[15:8] = din[15:8];
    return r;
  endfunction

  // Index map: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        chk($sformatf("rst_dout[%0d]", i), dv[i], 0);
        chk($sformatf("rst_valid[%0d]", i), vv[i], 0);
        last[i] = '0;
      end else if (vv[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("unexpected_valid[%0d]", i), vv[i], 0);
        end else begin
          mon_e = q[i].pop_front();
          chk($sformatf("rd_data[%0d]", i), dv[i], mon_e.data);
          chk($sformatf("rd_cycle[%0d]", i), cyc, mon_e.cyc);
        end
        last[i] = dv[i];
      end else begin
        chk($sformatf("dout_hold[%0d]", i), dv[i], last[i]);
        if (q[i].size() > 0 && q[i][0].cyc <= cyc) begin
          void'(q[i].pop_front());
          chk($sformatf("rd_valid_missing[%0d]", i), vv[i], 1);
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        chk($sformatf("rst_collision[%0d]", j), cv[j], 0);
      end else if (cv[j]) begin
        if (qc[j].size() == 0) chk($sformatf("unexpected_collision[%0d]", j), cv[j], 0);
        else chk($sformatf("collision_cycle[%0d]", j), cyc, qc[j].pop_front());
      end else if (qc[j].size() > 0 && qc[j][0] <= cyc) begin
        void'(qc[j].pop_front());
        chk($sformatf("collision_missing[%0d]", j), cv[j], 1);
      end
    end
  end

  task automatic set_idle();
    en_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;
  endtask

  task automatic drive_junk();
    en_a = 1; we_a = 1; be_a = 2'($urandom); addr_a = 4'($urandom); din_a = 16'($urandom);
    en_b = 1; we_b = 1; be_b = 2'($urandom); addr_b = 4'($urandom); din_b = 16'($urandom);
  endtask

  // One READY-state cycle: drive, predict reads and collision, then apply writes to the model.
  task automatic step(input logic ea, wa, input logic [1:0] ba, input logic [3:0] xa,
                      input logic [15:0] da,
                      input logic eb, wb, input logic [1:0] bb, input logic [3:0] xb,
                      input logic [15:0] db);
    logic [15:0] old_a, old_b;
    @(negedge clk);
    en_a = ea; we_a = wa; be_a = ba; addr_a = xa; din_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = xb; din_b = db;
    old_a = mem_m[xa];
    old_b = mem_m[xb];
    if (ea) begin
      q[0].push_back('{old_a, cyc + 1});
      q[2].push_back('{wa ? merge(old_a, da, ba) : old_a, cyc + 2});
    end
    if (eb) begin
      q[1].push_back('{old_b, cyc + 1});
      q[3].push_back('{wb ? merge(old_b, db, bb) : old_b, cyc + 2});
    end
    if (ea && wa && eb && wb && xa == xb && (ba & bb) != 2'b00) begin
      qc[0].push_back(cyc + 1);
      qc[1].push_back(cyc + 1);
    end
    if (eb && wb) mem_m[xb] = merge(mem_m[xb], db, bb);
    if (ea && wa) mem_m[xa] = merge(mem_m[xa], da, ba);
  endtask

  task automatic wait_clear();
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk("init_busy0", busy0, (i < 16));
      chk("init_busy1", busy1, (i < 16));
      @(negedge clk);
      if (i < 16) drive_junk();
      else set_idle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    set_idle();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_busy0", busy0, 1);
    chk("reset_busy1", busy1, 1);

    // Partial sweep, then a reset at clear step 8 restarts it; port activity is ignored throughout.
    rst = 0;
    drive_junk();
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk("partial_busy0", busy0, 1);
      @(negedge clk);
      drive_junk();
    end
    rst = 1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_busy0", busy0, 1);
      chk("rst_busy1", busy1, 1);
      @(negedge clk);
      drive_junk();
    end
    rst = 0;
    wait_clear();

    for (int a = 0; a < 16; a++)
      step(1, 0, 2'b00, 4'(a), 16'h0, 1, 0, 2'b00, 4'(15 - a), 16'h0);

    step(1, 1, 2'b11, 4'd3, 16'hA55A, 0, 0, 2'b00, 4'd0, 16'h0);
    step(0, 0, 2'b00, 4'd0, 16'h0,    1, 0, 2'b00, 4'd3, 16'h0);
    step(1, 1, 2'b01, 4'd3, 16'h00FF, 0, 0, 2'b00, 4'd0, 16'h0);
    step(1, 0, 2'b00, 4'd3, 16'h0,    1, 0, 2'b00, 4'd3, 16'h0);

    step(1, 1, 2'b11, 4'd7, 16'h1111, 0, 0, 2'b00, 4'd0, 16'h0);
    step(1, 1, 2'b11, 4'd7, 16'h2222, 1, 0, 2'b00, 4'd7, 16'h0);
    step(1, 0, 2'b00, 4'd7, 16'h0,    0, 0, 2'b00, 4'd0, 16'h0);

    step(1, 1, 2'b10, 4'd5, 16'hAAAA, 1, 1, 2'b11, 4'd5, 16'hBBBB);
    step(0, 0, 2'b00, 4'd0, 16'h0,    1, 0, 2'b00, 4'd5, 16'h0);
    step(1, 1, 2'b11, 4'd5, 16'h0000, 0, 0, 2'b00, 4'd0, 16'h0);
    step(1, 1, 2'b10, 4'd5, 16'hAAAA, 1, 1, 2'b01, 4'd5, 16'hBBBB);
    step(1, 0, 2'b00, 4'd5, 16'h0,    1, 0, 2'b00, 4'd5, 16'h0);

    step(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    for (int a = 0; a < 4; a++)
      step(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'(a), 16'h0);
    repeat (3) step(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);

    // Narrow address range keeps same-address and collision cases frequent.
    for (int n = 0; n < 400; n++)
      step(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));

    for (int a = 0; a < 16; a++)
      step(1, 0, 2'b00, 4'(a), 16'h0, 1, 0, 2'b00, 4'(a ^ 4'hF), 16'h0);
    repeat (4) step(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);

    for (int i = 0; i < 4; i++) chk($sformatf("read_queue_drained[%0d]", i), q[i].size(), 0);
    for (int j = 0; j < 2; j++) chk($sformatf("collision_queue_drained[%0d]", j), qc[j].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dualportram_param.md
# dualportram_param

Parametrised true dual-port synchronous RAM, the successor to the fixed 16x8 dual-port RAM. It adds generic width and depth, per-byte write enables, selectable read-during-write behaviour, and an optional output register stage with a valid flag. It also adds deterministic same-address write collision resolution and a post-reset hardware clear sequencer. It serves as the shared storage primitive for buffers and register files in the memory library.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W
- RDW_MODE, 0: same-port read-during-write; 0 = read-first (old word), 1 = write-first (new merged word)
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; restarts the clear sequence
- en_a / en_b  in  1  port access enable; no read or write when low
- we_a / we_b  in  1  write enable, qualified by en_x
- be_a / be_b  in  DATA_W/8  byte-lane write enables, qualified by we_x
- addr_a / addr_b  in  ADDR_W  word address
- din_a / din_b  in  DATA_W  write data
- dout_a / dout_b  out  DATA_W  read data; holds the last value when no read completes
- valid_a / valid_b  out  1  one-cycle pulse when dout_x carries a new read result
- init_busy  out  1  high while in reset or the clear sequence; ports are ignored while high
- collision  out  1  one-cycle pulse, registered; both ports wrote the same address with overlapping byte lanes

## Operation
- FSM states: CLEAR, READY.
  - rst high forces CLEAR with clear pointer = 0.
  - In CLEAR, one word per cycle is written to zero at the pointer, and the pointer increments.
  - After address DEPTH-1 is written, the FSM moves to READY.
  - rst asserted mid-clear restarts the sweep at 0.
- In CLEAR, en/we on both ports are ignored: no writes, no valid pulses.
- Every port access with en_x = 1 in READY performs a read. If we_x = 1, lanes with be_x[i] = 1 are also written from din_x.
  - A write with be_x = 0 is a pure read.
- Same-port read-during-write:
  - RDW_MODE 0 returns the pre-write word.
  - RDW_MODE 1 returns the stored word after the write: new bytes in enabled lanes, old bytes elsewhere.
- Cross-port read-during-write (port X reads the address port Y writes in the same cycle) always returns the pre-write word, independent of RDW_MODE.
- Both ports write the same address in the same cycle:
  - Lanes with be_a set take din_a.
  - Lanes with be_b set and be_a clear take din_b.
  - collision pulses only if be_a & be_b ≠ 0.
- Different addresses: the two ports are fully independent.

## Timing
- Reset values: dout_a = dout_b = 0, valid_a = valid_b = 0, collision = 0, init_busy = 1.
- init_busy stays 1 while rst is high. It falls exactly DEPTH cycles after the first edge with rst low (16 cycles at ADDR_W = 4).
- Read latency:
  - OUT_REG 0: a request at edge N is visible on dout/valid after edge N+1.
  - OUT_REG 1: visible after edge N+2.
  - Back-to-back reads are fully pipelined, one result per cycle per port.
- A write at edge N is visible to any read issued at edge N+1 or later on either port.
- collision rises after the edge following the offending write and lasts 1 cycle.
- valid_x is low in every cycle without a completing read. dout_x holds its value and is never zeroed except by rst.
- Address wrap: addresses are modulo DEPTH; no out-of-range condition exists.

## Test plan
Bench configuration for the scenarios: DATA_W = 16, ADDR_W = 4.
- Reset → init_busy high for 16 cycles after rst release; every address then reads 0x0000 with valid after 1 cycle (OUT_REG 0).
- Port A writes 0xA55A, be = 11, to addr 3; port B reads addr 3 next cycle → dout_b = 0xA55A.
  - Then port A writes be = 01, din 0x00FF, to addr 3 → reads back 0xA5FF.
- Same-port read-during-write: addr 7 holds 0x1111; port A writes 0x2222 while reading addr 7 → dout_a = 0x1111 with RDW_MODE 0, 0x2222 with RDW_MODE 1.
  - In the same cycle, port B reading addr 7 → 0x1111 in both modes.
- Dual write to addr 5:
  - A = 0xAAAA with be 10, B = 0xBBBB with be 11 → stored 0xAABB, collision pulses 1 cycle.
  - A be 10, B be 01 → 0xAABB, no collision.
- OUT_REG 1: streaming reads of addrs 0..3 on port B → values appear on consecutive cycles starting 2 cycles after the first request; valid_b high for exactly 4 cycles.
- rst asserted at clear step 8 → sweep restarts. Writes attempted while init_busy is high leave memory 0, with no valid pulses.
